// File: rtl/fc3_result_reader_pkg.sv
// Shared constants and FSM encodings for the fc_3 result reader.
package fc3_result_reader_pkg;

  localparam int RR_N_CLASS = 10;
  localparam int RR_DW      = 16;
  localparam int RR_IDXW    = 4;

  typedef enum logic [1:0] {
    RR_IDLE   = 2'd0,
    RR_ARGMAX = 2'd1,
    RR_OUT    = 2'd2
  } rr_state_e;

endpackage

// File: rtl/fc3_result_reader_argmax.sv
// Sequential signed argmax over a captured score vector; strict compare keeps the lowest index on ties.
module fc3_argmax_unit
  import fc3_result_reader_pkg::*;
#(
  parameter int N_CLASS = RR_N_CLASS,
  parameter int DW      = RR_DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [N_CLASS*DW-1:0]       i_scores,
  output logic signed [DW-1:0]        o_max_val,
  output logic [RR_IDXW-1:0]          o_max_idx,
  output logic                        o_done
);

  localparam logic [RR_IDXW-1:0] LAST_IDX = RR_IDXW'(N_CLASS - 1);

  logic                       r_active;
  logic [RR_IDXW-1:0]         r_idx;
  logic signed [DW-1:0]       r_max_val;
  logic [RR_IDXW-1:0]         r_max_idx;
  logic                       r_done;
  logic signed [DW-1:0]       w_cur;

  assign w_cur = i_scores[r_idx*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_idx     <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_idx    <= '0;
      end else if (r_active) begin
        if ((r_idx == '0) || (w_cur > r_max_val)) begin
          r_max_val <= w_cur;
          r_max_idx <= r_idx;
        end
        if (r_idx == LAST_IDX) begin
          r_active <= 1'b0;
          r_idx    <= '0;
          r_done   <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_max_val = r_max_val;
  assign o_max_idx = r_max_idx;
  assign o_done    = r_done;

endmodule

// File: rtl/fc3_result_reader.sv
// Captures fc_3 class scores, runs argmax, and presents the winner plus a raw score stream.
module fc3_result_reader
  import fc3_result_reader_pkg::*;
#(
  parameter int N_CLASS = RR_N_CLASS,
  parameter int DW      = RR_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fc_3_finish,
  input  logic [N_CLASS*DW-1:0] result_10x16,
  output logic [RR_IDXW-1:0]    class_id,
  output logic [DW-1:0]         class_score,
  output logic                  class_vld,
  input  logic                  class_rdy,
  output logic [DW-1:0]         score_tdata,
  output logic                  score_tvalid,
  input  logic                  score_tready,
  output logic                  score_tlast,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [RR_IDXW-1:0] LAST_IDX = RR_IDXW'(N_CLASS - 1);

  rr_state_e                r_state;
  logic                     r_fin_d;
  logic [N_CLASS*DW-1:0]    r_buf;
  logic                     r_overrun;
  logic                     r_class_vld;
  logic [RR_IDXW-1:0]       r_class_id;
  logic [DW-1:0]            r_class_score;
  logic [DW-1:0]            r_tdata;
  logic                     r_tvalid;
  logic                     r_tlast;
  logic [RR_IDXW-1:0]       r_beat;
  logic                     r_cls_done;
  logic                     r_str_done;

  logic                     w_fin_p;
  logic                     w_start;
  logic [RR_IDXW-1:0]       w_next_beat;
  logic signed [DW-1:0]     w_max_val;
  logic [RR_IDXW-1:0]       w_max_idx;
  logic                     w_am_done;

  assign w_fin_p     = fc_3_finish & ~r_fin_d;
  assign w_start     = w_fin_p && (r_state == RR_IDLE);
  assign w_next_beat = r_beat + 1'b1;

  fc3_argmax_unit #(
    .N_CLASS (N_CLASS),
    .DW      (DW)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_scores  (r_buf),
    .o_max_val (w_max_val),
    .o_max_idx (w_max_idx),
    .o_done    (w_am_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RR_IDLE;
      r_fin_d       <= 1'b1;
      r_buf         <= '0;
      r_overrun     <= 1'b0;
      r_class_vld   <= 1'b0;
      r_class_id    <= '0;
      r_class_score <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_beat        <= '0;
      r_cls_done    <= 1'b0;
      r_str_done    <= 1'b0;
    end else begin
      r_fin_d <= fc_3_finish;
      if (w_fin_p && (r_state != RR_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        RR_IDLE: begin
          if (w_fin_p) begin
            r_buf   <= result_10x16;
            r_state <= RR_ARGMAX;
          end
        end
        RR_ARGMAX: begin
          if (w_am_done) begin
            r_state       <= RR_OUT;
            r_class_vld   <= 1'b1;
            r_class_id    <= w_max_idx;
            r_class_score <= w_max_val;
            r_tvalid      <= 1'b1;
            r_tdata       <= r_buf[DW-1:0];
            r_tlast       <= (N_CLASS == 1);
            r_beat        <= '0;
            r_cls_done    <= 1'b0;
            r_str_done    <= 1'b0;
          end
        end
        RR_OUT: begin
          // Completion flags are registered, so IDLE follows one cycle after the later handshake.
          if (r_cls_done && r_str_done) begin
            r_state <= RR_IDLE;
          end
          if (r_class_vld && class_rdy) begin
            r_class_vld <= 1'b0;
            r_cls_done  <= 1'b1;
          end
          if (r_tvalid && score_tready) begin
            if (r_beat == LAST_IDX) begin
              r_tvalid   <= 1'b0;
              r_tlast    <= 1'b0;
              r_str_done <= 1'b1;
            end else begin
              r_beat  <= w_next_beat;
              r_tdata <= r_buf[w_next_beat*DW +: DW];
              r_tlast <= (w_next_beat == LAST_IDX);
            end
          end
        end
        default: r_state <= RR_IDLE;
      endcase
    end
  end

  assign class_id     = r_class_id;
  assign class_score  = r_class_score;
  assign class_vld    = r_class_vld;
  assign score_tdata  = r_tdata;
  assign score_tvalid = r_tvalid;
  assign score_tlast  = r_tlast;
  assign busy         = (r_state != RR_IDLE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_fc3_result_reader.sv
// Directed bench for fc3_result_reader with hand-computed expectations.
module tb_fc3_result_reader;

  localparam int NC = 10;
  localparam int W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              fc_3_finish;
  logic [NC*W-1:0]   result_10x16;
  logic [3:0]        class_id;
  logic [W-1:0]      class_score;
  logic              class_vld;
  logic              class_rdy;
  logic [W-1:0]      score_tdata;
  logic              score_tvalid;
  logic              score_tready;
  logic              score_tlast;
  logic              busy;
  logic              overrun;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [W-1:0] sa [NC];

  always #5 clk = ~clk;

  fc3_result_reader #(
    .N_CLASS (NC),
    .DW      (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fc_3_finish  (fc_3_finish),
    .result_10x16 (result_10x16),
    .class_id     (class_id),
    .class_score  (class_score),
    .class_vld    (class_vld),
    .class_rdy    (class_rdy),
    .score_tdata  (score_tdata),
    .score_tvalid (score_tvalid),
    .score_tready (score_tready),
    .score_tlast  (score_tlast),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load();
    for (int i = 0; i < NC; i++) result_10x16[i*W +: W] = sa[i];
  endtask

  // Returns at the first falling edge after the capture edge, with fc_3_finish low again.
  task automatic fire();
    load();
    fc_3_finish = 1'b0;
    cyc(1);
    fc_3_finish = 1'b1;
    cyc(1);
    fc_3_finish = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_id"},     16'(class_id),     16'd0);
    check({tag, "_score"},  class_score,       16'd0);
    check({tag, "_vld"},    16'(class_vld),    16'd0);
    check({tag, "_tdata"},  score_tdata,       16'd0);
    check({tag, "_tvalid"}, 16'(score_tvalid), 16'd0);
    check({tag, "_tlast"},  16'(score_tlast),  16'd0);
    check({tag, "_busy"},   16'(busy),         16'd0);
    check({tag, "_ovr"},    16'(overrun),      16'd0);
  endtask

  initial begin
    int beats;
    logic prev_stall;
    logic [W-1:0] prev_td;

    rst          = 1'b1;
    fc_3_finish  = 1'b0;
    class_rdy    = 1'b1;
    score_tready = 1'b1;
    result_10x16 = '0;
    cyc(3);
    check_all_zero("rst");
    rst = 1'b0;
    cyc(2);

    // T1: nominal result, both sinks always ready
    sa = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd12, 16'sd0, -16'sd1, 16'sd2, 16'sd11, 16'sd4};
    fire();                                             // k=1
    check("t1_busy_rise", 16'(busy), 16'd1);
    cyc(10);                                            // k=11
    check("t1_vld_early", 16'(class_vld), 16'd0);
    check("t1_tvalid_early", 16'(score_tvalid), 16'd0);
    cyc(1);                                             // k=12
    check("t1_vld", 16'(class_vld), 16'd1);
    check("t1_id", 16'(class_id), 16'd2);
    check("t1_score", class_score, 16'd12);
    check("t1_tvalid", 16'(score_tvalid), 16'd1);
    check("t1_beat0", score_tdata, sa[0]);
    check("t1_last0", 16'(score_tlast), 16'd0);
    for (int j = 1; j < NC; j++) begin
      cyc(1);
      check("t1_beat", score_tdata, sa[j]);
      check("t1_last", 16'(score_tlast), (j == NC-1) ? 16'd1 : 16'd0);
      if (j == 1) check("t1_vld_drop", 16'(class_vld), 16'd0);
    end
    cyc(1);                                             // k=22
    check("t1_tvalid_drop", 16'(score_tvalid), 16'd0);
    check("t1_busy_k22", 16'(busy), 16'd1);
    cyc(1);                                             // k=23
    check("t1_busy_end", 16'(busy), 16'd0);
    check("t1_ovr", 16'(overrun), 16'd0);

    // T2: all negative, tie between classes 1 and 2
    sa = '{-16'sd100, -16'sd7, -16'sd7, -16'sd20, -16'sd300, -16'sd8, -16'sd9, -16'sd32768, -16'sd50, -16'sd200};
    fire();
    for (int i = 0; i < 40 && !class_vld; i++) cyc(1);
    check("t2_vld_seen", 16'(class_vld), 16'd1);
    check("t2_id", 16'(class_id), 16'd1);
    check("t2_score", class_score, 16'hFFF9);
    for (int i = 0; i < 40 && busy; i++) cyc(1);
    check("t2_idle", 16'(busy), 16'd0);

    // T3: stream stalls then toggles, class_rdy pulsed once
    sa = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd12, 16'sd0, -16'sd1, 16'sd2, 16'sd11, 16'sd4};
    class_rdy    = 1'b0;
    score_tready = 1'b0;
    fire();
    cyc(11);                                            // k=12
    check("t3_vld", 16'(class_vld), 16'd1);
    check("t3_tvalid", 16'(score_tvalid), 16'd1);
    beats      = 0;
    prev_stall = 1'b0;
    prev_td    = '0;
    for (int c = 0; c < 80 && beats < NC; c++) begin
      if (prev_stall) check("t3_stable", score_tdata, prev_td);
      if (c == 2) check("t3_vld_hold", 16'(class_vld), 16'd1);
      if (c == 3) check("t3_vld_drop", 16'(class_vld), 16'd0);
      if (c == 4) check("t3_busy_mid", 16'(busy), 16'd1);
      class_rdy    = (c == 2);
      score_tready = (c < 5) ? 1'b0 : ((c - 5) % 2 == 0);
      if (score_tvalid && score_tready) begin
        check("t3_beat", score_tdata, sa[beats]);
        check("t3_last", 16'(score_tlast), (beats == NC-1) ? 16'd1 : 16'd0);
        beats++;
      end
      prev_stall = score_tvalid && !score_tready;
      prev_td    = score_tdata;
      cyc(1);
    end
    check("t3_beats", 16'(beats), 16'(NC));
    check("t3_tvalid_drop", 16'(score_tvalid), 16'd0);
    check("t3_busy_after_last", 16'(busy), 16'd1);
    cyc(1);
    check("t3_idle", 16'(busy), 16'd0);
    class_rdy    = 1'b1;
    score_tready = 1'b1;

    // T4: second finish edge during ARGMAX
    fire();                                             // k=1, data A
    cyc(2);                                             // k=3
    check("t4_ovr_pre", 16'(overrun), 16'd0);
    sa = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100, 16'sd0, -16'sd5};
    load();
    fc_3_finish = 1'b1;
    cyc(1);                                             // k=4
    check("t4_ovr_set", 16'(overrun), 16'd1);
    fc_3_finish = 1'b0;
    for (int i = 0; i < 40 && !class_vld; i++) cyc(1);
    check("t4_id", 16'(class_id), 16'd2);
    check("t4_score", class_score, 16'd12);
    check("t4_beat0", score_tdata, 16'd5);
    for (int i = 0; i < 40 && busy; i++) cyc(1);
    check("t4_idle", 16'(busy), 16'd0);
    cyc(3);
    check("t4_ovr_sticky", 16'(overrun), 16'd1);

    // T5: asynchronous reset in OUT, finish high at release
    sa = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd12, 16'sd0, -16'sd1, 16'sd2, 16'sd11, 16'sd4};
    class_rdy    = 1'b0;
    score_tready = 1'b0;
    fire();
    cyc(11);                                            // k=12, in OUT
    check("t5_vld_before", 16'(class_vld), 16'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("t5_async");
    cyc(1);
    fc_3_finish = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(15);
    check("t5_no_capture_busy", 16'(busy), 16'd0);
    check("t5_no_capture_vld", 16'(class_vld), 16'd0);
    class_rdy    = 1'b1;
    score_tready = 1'b1;
    sa = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100, 16'sd0, -16'sd5};
    fire();                                             // k=1
    cyc(11);                                            // k=12
    check("t5_vld", 16'(class_vld), 16'd1);
    check("t5_id", 16'(class_id), 16'd7);
    check("t5_score", class_score, 16'd100);
    cyc(10);                                            // k=22, last cycle before IDLE
    check("t5_busy_k22", 16'(busy), 16'd1);
    fc_3_finish = 1'b1;                                 // rising edge lands on the return to IDLE
    cyc(1);                                             // k=23
    check("t5_ovr_at_return", 16'(overrun), 16'd1);
    check("t5_idle_k23", 16'(busy), 16'd0);
    cyc(1);
    check("t5_idle_k24", 16'(busy), 16'd0);
    fc_3_finish = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
